// File: rtl/ga_pkg.sv
// Shared types and sizing helpers for the GA best-chromosome logger.
// Define GA_LOG_FITNESS_EN to store {best_fit, best} per entry instead of best alone.
package ga_pkg;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DUMP    = 2'd1,
    DONE    = 2'd2
  } ga_state_e;

`ifdef GA_LOG_FITNESS_EN
  localparam int GA_FIT_EN = 1;
`else
  localparam int GA_FIT_EN = 0;
`endif

  // Width of one history entry; fitness sits in the MSBs when it is logged.
  function automatic int ga_dw(input int cw, input int fw);
    return cw + ((GA_FIT_EN != 0) ? fw : 0);
  endfunction

endpackage

// File: rtl/ga_log_ram.sv
// Simple dual-port history RAM: one write port, one synchronous read port.
// A read of the address being written in the same cycle returns the new data.
module ga_log_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port; output holds while re is low so it can act as a pipeline stage
  always_ff @(posedge clk) begin
    if (re) begin
      if (we && (waddr == raddr)) begin
        rdata <= wdata;
      end else begin
        rdata <= mem_r[raddr];
      end
    end
  end

endmodule

// File: rtl/ga_best_logger.sv
// Records the GA's best chromosome each generation, then streams the history out.
// Define GA_LOG_FITNESS_EN to log {best_fit, best}; otherwise only best is stored.
module ga_best_logger
  import ga_pkg::*;
#(
  parameter int GENS          = 1000,
  parameter int CHROM_WIDTH   = 16,
  parameter int FITNESS_WIDTH = (CHROM_WIDTH + 1) * 3
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [CHROM_WIDTH-1:0]                          best,
  input  logic [FITNESS_WIDTH-1:0]                        best_fit,
  input  logic                                            gen_valid,
  input  logic                                            finished,
  output logic [ga_dw(CHROM_WIDTH, FITNESS_WIDTH)-1:0]    out_data,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic                                            out_last,
  output logic [$clog2(GENS+1)-1:0]                       count,
  output logic                                            overflow,
  output logic                                            done
);

  localparam int DW = ga_dw(CHROM_WIDTH, FITNESS_WIDTH);
  localparam int CW = $clog2(GENS + 1);
  localparam int AW = (GENS > 1) ? $clog2(GENS) : 1;
  localparam logic [CW-1:0] GENS_C = CW'(GENS);
  localparam logic [CW-1:0] ONE_C  = CW'(1'b1);

  ga_state_e      state_r;
  logic [CW-1:0]  count_r;
  logic [CW-1:0]  rd_ptr_r;
  logic           rd_vld_r;
  logic [DW-1:0]  out_data_r;
  logic           out_valid_r;
  logic           out_last_r;
  logic           overflow_r;
  logic           done_r;

  logic           wr_en_s;
  logic [DW-1:0]  wr_data_s;
  logic [CW-1:0]  cnt_next_s;
  logic           drop_s;
  logic           rd_en_s;
  logic [AW-1:0]  rd_addr_s;
  logic [DW-1:0]  rd_data_s;
  logic           load_out_s;
  logic           rd_last_s;
  logic           xfer_s;

`ifdef GA_LOG_FITNESS_EN
  assign wr_data_s = {best_fit, best};
`else
  logic unused_fit_s;
  assign wr_data_s    = best;
  assign unused_fit_s = ^best_fit;
`endif

  ga_log_ram #(
    .DEPTH (GENS),
    .WIDTH (DW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (count_r[AW-1:0]),
    .wdata (wr_data_s),
    .re    (rd_en_s),
    .raddr (rd_addr_s),
    .rdata (rd_data_s)
  );

  // Capture/drop decisions and the two-stage (RAM output + output register) read pipeline control
  always_comb begin
    wr_en_s    = 1'b0;
    cnt_next_s = count_r;
    drop_s     = 1'b0;
    rd_en_s    = 1'b0;
    rd_addr_s  = '0;
    load_out_s = 1'b0;
    xfer_s     = out_valid_r && out_ready;
    rd_last_s  = (rd_ptr_r == count_r);
    case (state_r)
      CAPTURE: begin
        if (gen_valid) begin
          if (count_r < GENS_C) begin
            wr_en_s    = 1'b1;
            cnt_next_s = count_r + ONE_C;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          drop_s = 1'b0;
        end
        // Prefetch entry 0 on the way into DUMP so the first beat is ready one cycle later
        if (finished && (cnt_next_s != '0)) begin
          rd_en_s = 1'b1;
        end else begin
          rd_en_s = 1'b0;
        end
      end
      DUMP: begin
        load_out_s = rd_vld_r && (!out_valid_r || out_ready);
        rd_en_s    = (rd_ptr_r < count_r) && (!rd_vld_r || load_out_s);
        rd_addr_s  = rd_ptr_r[AW-1:0];
      end
      default: begin
        rd_en_s = 1'b0;
      end
    endcase
  end

  // Logger FSM with registered stream and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= CAPTURE;
      count_r     <= '0;
      rd_ptr_r    <= '0;
      rd_vld_r    <= 1'b0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      overflow_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        CAPTURE: begin
          count_r <= cnt_next_s;
          if (drop_s) begin
            overflow_r <= 1'b1;
          end
          if (finished) begin
            if (cnt_next_s == '0) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r  <= DUMP;
              rd_ptr_r <= ONE_C;
              rd_vld_r <= 1'b1;
            end
          end
        end
        DUMP: begin
          if (xfer_s && out_last_r) begin
            state_r     <= DONE;
            done_r      <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            rd_vld_r    <= 1'b0;
          end else begin
            if (load_out_s) begin
              out_data_r  <= rd_data_s;
              out_valid_r <= 1'b1;
              out_last_r  <= rd_last_s;
            end else if (xfer_s) begin
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
            end
            if (rd_en_s) begin
              rd_ptr_r <= rd_ptr_r + ONE_C;
              rd_vld_r <= 1'b1;
            end else if (load_out_s) begin
              rd_vld_r <= 1'b0;
            end
          end
        end
        DONE: begin
          done_r      <= 1'b1;
          out_valid_r <= 1'b0;
        end
        default: begin
          state_r <= CAPTURE;
        end
      endcase
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign done      = done_r;

endmodule

// File: tb/tb_ga_best_logger.sv
// Scoreboard bench for ga_best_logger: directed scenarios plus randomized runs.
module tb_ga_best_logger;
  import ga_pkg::*;

  localparam int GENS = 4;
  localparam int CHW  = 16;
  localparam int FW   = (CHW + 1) * 3;
  localparam int DW   = ga_dw(CHW, FW);
  localparam int NW   = $clog2(GENS + 1);

  logic           clk = 1'b0;
  logic           reset;
  logic [CHW-1:0] best;
  logic [FW-1:0]  best_fit;
  logic           gen_valid;
  logic           finished;
  logic [DW-1:0]  out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic [NW-1:0]  count;
  logic           overflow;
  logic           done;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  logic [DW-1:0]  exp_q[$];
  logic [CHW-1:0] vals[8];
  logic [FW-1:0]  fits[8];
  int             pat[4] = '{1, 0, 0, 1};

  ga_best_logger #(.GENS(GENS), .CHROM_WIDTH(CHW), .FITNESS_WIDTH(FW)) dut (
    .clk(clk), .reset(reset), .best(best), .best_fit(best_fit),
    .gen_valid(gen_valid), .finished(finished), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .count(count), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] entry(input logic [CHW-1:0] b, input logic [FW-1:0] f);
    logic unused_f;
    unused_f = ^f;
`ifdef GA_LOG_FITNESS_EN
    return {f, b};
`else
    return b;
`endif
  endfunction

  // Monitor: every handshake pops the scoreboard; stalled beats must hold steady
  initial begin
    logic          hold_v;
    logic [DW-1:0] hold_d;
    logic          hold_l;
    logic [DW-1:0] e;
    hold_v = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        chk("valid_in_done", 128'(done && out_valid), 128'(0));
        if (out_valid && hold_v) begin
          chk("stall_data", 128'(out_data), 128'(hold_d));
          chk("stall_last", 128'(out_last), 128'(hold_l));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected no beat", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", 128'(out_data), 128'(e));
            chk("beat_last", 128'(out_last), 128'(exp_q.size() == 0));
          end
          beats++;
          hold_v = 1'b0;
        end else if (out_valid) begin
          hold_v = 1'b1;
          hold_d = out_data;
          hold_l = out_last;
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; gen_valid = 1'b0; finished = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_last",  128'(out_last),  128'(0));
    chk("rst_out_data",  128'(out_data),  128'(0));
    chk("rst_count",     128'(count),     128'(0));
    chk("rst_overflow",  128'(overflow),  128'(0));
    chk("rst_done",      128'(done),      128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // rmode: 0 random ready, 1 ready held high, 2 ready pattern 1,0,0,1
  task automatic drive_dump(input int rmode, input int cyc);
    if (rmode == 1) out_ready = 1'b1;
    else if (rmode == 2) out_ready = 1'(pat[(cyc + 3) % 4]);
    else out_ready = 1'($urandom_range(0, 1));
    gen_valid = 1'($urandom_range(0, 1));
    best      = CHW'($urandom());
    best_fit  = FW'({$urandom(), $urandom()});
  endtask

  task automatic do_run(input int n, input int rmode, input bit same, input bit abort);
    int cyc;
    int exp_cnt;
    cyc     = 0;
    beats   = 0;
    exp_cnt = (n < GENS) ? n : GENS;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      gen_valid = 1'b1; best = vals[i]; best_fit = fits[i];
      finished  = same && (i == n - 1);
      if (i < GENS) exp_q.push_back(entry(vals[i], fits[i]));
      if (rmode == 0 && !(same && i == n - 1) && $urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        gen_valid = 1'b0;
      end
    end
    if (!(same && n > 0)) begin
      @(posedge clk); #1;
      gen_valid = 1'b0; finished = 1'b1;
    end
    @(posedge clk); #1;
    finished = 1'b0;
    drive_dump(rmode, cyc); cyc++;
    @(negedge clk);
    chk("first_beat_early", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    drive_dump(rmode, cyc); cyc++;
    @(negedge clk);
    chk("first_beat_latency", 128'(out_valid), 128'(n > 0));
    if (n == 0) chk("empty_done", 128'(done), 128'(1));
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      if (abort && beats > 0) begin
        reset = 1'b1; out_ready = 1'b0; gen_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_out_last",  128'(out_last),  128'(0));
        chk("abort_out_data",  128'(out_data),  128'(0));
        chk("abort_count",     128'(count),     128'(0));
        chk("abort_overflow",  128'(overflow),  128'(0));
        chk("abort_done",      128'(done),      128'(0));
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      drive_dump(rmode, cyc); cyc++;
      @(negedge clk);
    end
    chk("done_timeout", 128'(done), 128'(1));
    chk("all_beats_out", 128'(exp_q.size()), 128'(0));
    chk("final_count", 128'(count), 128'(exp_cnt));
    chk("final_overflow", 128'(overflow), 128'(n > GENS));
    chk("final_out_valid", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    gen_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    int n;
    best = '0; best_fit = '0;
    for (int i = 0; i < 8; i++) fits[i] = FW'({$urandom(), $urandom()});
    do_reset();
    vals[0] = 16'd10; vals[1] = 16'd20; vals[2] = 16'd30;
    do_run(3, 1, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) vals[i] = CHW'(i + 1);
    do_run(6, 1, 1'b0, 1'b0);
    do_reset();
    do_run(0, 1, 1'b0, 1'b0);
    do_reset();
    vals[0] = 16'd5; vals[1] = 16'd6;
    do_run(2, 2, 1'b0, 1'b0);
    do_reset();
    vals[0] = 16'd1; vals[1] = 16'd2; vals[2] = 16'd3;
    do_run(3, 1, 1'b0, 1'b1);
    vals[0] = 16'd7; vals[1] = 16'd8;
    do_run(2, 1, 1'b0, 1'b0);
    do_reset();
    vals[0] = 16'h00AA; fits[0] = FW'(3);
    do_run(1, 1, 1'b1, 1'b0);
    for (int r = 0; r < 14; r++) begin
      do_reset();
      n = $urandom_range(0, 6);
      for (int i = 0; i < 8; i++) begin
        vals[i] = CHW'($urandom());
        fits[i] = FW'({$urandom(), $urandom()});
      end
      do_run(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
